// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family.
package fifo_pkg;

  // Default geometry of the FIFO.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Read-mode selection values for the FWFT parameter.
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2. Returns 0 for values of 1 or less.
  function automatic int clog2_f(input int value);
    int result;
    int one;
    result = 0;
    one    = 1;
    for (int i = 0; i < 31; i++) begin
      if ((one << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, combinational read.
// The read register lives in the parent so that it can pick the address
// it needs for either read mode.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the incoming word on an accepted write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, overflow/underflow pulses and standard or FWFT read mode.
// All status outputs are registered and change on the same edge as the
// pointers they describe.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_STD
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [clog2_f(DEPTH):0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = clog2_f(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_THR  = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR  = PW'(AE_LEVEL);
  localparam bit            IS_FWFT = (FWFT == FIFO_FWFT);

  // Build-time parameter sanity checks.
  if ((DEPTH < 4) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_err
    $error("sync_fifo_param: DEPTH=%0d must be a power of two in 4..1024", DEPTH);
  end
  if ((WIDTH < 1) || (WIDTH > 64)) begin : g_width_err
    $error("sync_fifo_param: WIDTH=%0d must be in 1..64", WIDTH);
  end
  if ((AF_LEVEL < 0) || (AF_LEVEL > DEPTH)) begin : g_af_err
    $error("sync_fifo_param: AF_LEVEL=%0d must be in 0..DEPTH", AF_LEVEL);
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH)) begin : g_ae_err
    $error("sync_fifo_param: AE_LEVEL=%0d must be in 0..DEPTH", AE_LEVEL);
  end
  if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_mode_err
    $error("sync_fifo_param: FWFT=%0d must be 0 or 1", FWFT);
  end

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [PW-1:0]    count_nxt_s;
  logic             rd_acc_s;
  logic             wr_acc_s;
  logic             empty_nxt_s;
  logic             full_nxt_s;
  logic [AW-1:0]    mem_rd_addr_s;
  logic [WIDTH-1:0] mem_rd_data_s;
  logic [WIDTH-1:0] head_nxt_s;

  // Accept decisions, next pointers, next occupancy and next flags.
  always_comb begin
    rd_acc_s     = rd_en & ~empty;
    wr_acc_s     = wr_en & (~full | rd_acc_s);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count;
    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count + PTR_ONE;
      2'b01:   count_nxt_s = count - PTR_ONE;
      default: count_nxt_s = count;
    endcase
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]) &&
                  (wr_ptr_nxt_s[PW-1] != rd_ptr_nxt_s[PW-1]);
  end

  // Read-address and head-word selection. FWFT prefetches the word that will
  // be at the head after this edge; when that word is the one being written
  // right now it is taken straight from wr_data.
  always_comb begin
    mem_rd_addr_s = rd_ptr_r[AW-1:0];
    head_nxt_s    = mem_rd_data_s;
    if (IS_FWFT) begin
      mem_rd_addr_s = rd_ptr_nxt_s[AW-1:0];
      if (wr_acc_s && (count_nxt_s == PTR_ONE)) begin
        head_nxt_s = wr_data;
      end else begin
        head_nxt_s = mem_rd_data_s;
      end
    end else begin
      mem_rd_addr_s = rd_ptr_r[AW-1:0];
      head_nxt_s    = mem_rd_data_s;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (wr_acc_s),
    .wr_addr (wr_ptr_r[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (mem_rd_addr_s),
    .rd_data (mem_rd_data_s)
  );

  // Pointer, occupancy, flag, error-pulse and read-port registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count        <= {PW{1'b0}};
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      count        <= count_nxt_s;
      empty        <= empty_nxt_s;
      full         <= full_nxt_s;
      almost_empty <= (count_nxt_s <= AE_THR);
      almost_full  <= (count_nxt_s >= AF_THR);
      overflow     <= wr_en & ~wr_acc_s;
      underflow    <= rd_en & ~rd_acc_s;
      if (IS_FWFT) begin
        rd_valid <= ~empty_nxt_s;
        if (!empty_nxt_s) begin
          rd_data <= head_nxt_s;
        end
      end else begin
        rd_valid <= rd_acc_s;
        if (rd_acc_s) begin
          rd_data <= head_nxt_s;
        end
      end
    end
  end

endmodule : sync_fifo_param
